aw_wlast_ctrl: RTL and testbench

Write-channel counterpart of the read-side burst-length FIFO. It queues the AXI3 burst length of every accepted AW transfer and gates the write-DMA data stream onto the AXI W channel. It counts beats, generates `m_wlast` on the final beat of each burst, and tracks outstanding B responses. It sits between the write DMA and the HP port AXI master interface.

---
 rtl/aw_wlast_ctrl_pkg.sv | 36 +++
 rtl/aw_wlast_ctrl_len_fifo.sv | 77 +++++++
 rtl/aw_wlast_ctrl.sv | 126 ++++++++++++
 tb/tb_aw_wlast_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aw_wlast_ctrl_pkg.sv
// Shared constants for the AXI3 write-channel burst gate: response encodings,
// error codes and the first-error priority encoder.
package aw_wlast_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BRESP   = 2'b01;
  localparam logic [1:0] ERR_AW_OVF  = 2'b10;
  localparam logic [1:0] ERR_UNEXP_B = 2'b11;

  typedef struct packed {
    logic bad_bresp;
    logic aw_ovf;
    logic unexp_b;
  } err_src_t;

  // When several causes coincide in one cycle, the lowest code wins.
  function automatic logic [1:0] err_encode(input err_src_t src);
    logic [1:0] code;
    if (src.bad_bresp) begin
      code = ERR_BRESP;
    end else if (src.aw_ovf) begin
      code = ERR_AW_OVF;
    end else if (src.unexp_b) begin
      code = ERR_UNEXP_B;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/aw_wlast_ctrl_len_fifo.sv
// Pointer-based burst-length FIFO; the extra pointer MSB is a wrap bit that
// separates full from empty when the low bits match.
module len_fifo
  import aw_wlast_ctrl_pkg::*;
#(
  parameter int W         = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_n_o,
  input  logic         pop_i,
  output logic         empty_n_o,
  output logic [W-1:0] head_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE = (DEPTH_LOG + 1)'(1);

  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]       mem_q [DEPTH];
  logic               low_eq_s;
  logic               wrap_eq_s;
  logic               do_push_s;
  logic               do_pop_s;

  // Full/empty status and head, all from registered pointers.
  always_comb begin
    low_eq_s  = (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
    wrap_eq_s = (wr_ptr_q[DEPTH_LOG] == rd_ptr_q[DEPTH_LOG]);
    empty_n_o = !(low_eq_s && wrap_eq_s);
    full_n_o  = !(low_eq_s && !wrap_eq_s);
    do_push_s = push_i && full_n_o;
    do_pop_s  = pop_i && empty_n_o;
    head_o    = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];
  end

  // Pointer next-state.
  always_comb begin
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {(DEPTH_LOG + 1){1'b0}};
      rd_ptr_q <= {(DEPTH_LOG + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Length storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/aw_wlast_ctrl.sv
// Queues AXI3 AW burst lengths, gates the DMA write stream onto W with wlast
// generation, and tracks outstanding B responses with a sticky first-error code.
module aw_wlast_ctrl
  import aw_wlast_ctrl_pkg::*;
#(
  parameter int LEN_W     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  wdma_awlen,
  input  logic              aw_fire,
  output logic              aw_fifo_full_n,
  input  logic [DATA_W-1:0] src_wdata,
  input  logic              src_wvalid,
  output logic              src_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic              m_wlast,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready,
  output logic              idle,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [LEN_W-1:0]   BEAT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]   BEAT_ONE  = LEN_W'(1);
  localparam logic [DEPTH_LOG:0] PEND_ZERO = {(DEPTH_LOG + 1){1'b0}};
  localparam logic [DEPTH_LOG:0] PEND_ONE  = (DEPTH_LOG + 1)'(1);

  logic             fifo_empty_n_s;
  logic [LEN_W-1:0] head_len_s;
  logic             w_fire_s;
  logic             last_fire_s;
  err_src_t         err_src_s;

  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DEPTH_LOG:0] b_pend_q, b_pend_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;

  len_fifo #(
    .W         (LEN_W),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_len_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (aw_fire),
    .din_i     (wdma_awlen),
    .full_n_o  (aw_fifo_full_n),
    .pop_i     (last_fire_s),
    .empty_n_o (fifo_empty_n_s),
    .head_o    (head_len_s)
  );

  // W pass-through, gated while no burst length is queued.
  always_comb begin
    m_wdata     = src_wdata;
    m_wvalid    = src_wvalid && fifo_empty_n_s;
    src_wready  = m_wready && fifo_empty_n_s;
    m_wlast     = fifo_empty_n_s && (beat_cnt_q == head_len_s);
    w_fire_s    = m_wvalid && m_wready;
    last_fire_s = w_fire_s && m_wlast;
    m_bready    = 1'b1;
    idle        = !fifo_empty_n_s && (beat_cnt_q == BEAT_ZERO) && (b_pend_q == PEND_ZERO);
    err         = err_q;
    err_code    = err_code_q;
  end

  // Beat counter and outstanding-B counter next-state.
  always_comb begin
    if (last_fire_s) begin
      beat_cnt_d = BEAT_ZERO;
    end else if (w_fire_s) begin
      beat_cnt_d = beat_cnt_q + BEAT_ONE;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    case ({last_fire_s, m_bvalid})
      2'b10: b_pend_d = b_pend_q + PEND_ONE;
      2'b01: begin
        // A B with nothing pending is flagged, never allowed to underflow.
        if (b_pend_q != PEND_ZERO) begin
          b_pend_d = b_pend_q - PEND_ONE;
        end else begin
          b_pend_d = b_pend_q;
        end
      end
      default: b_pend_d = b_pend_q;
    endcase
  end

  // Sticky error capture: only the first cause is kept.
  always_comb begin
    err_src_s.bad_bresp = m_bvalid && (m_bresp != RESP_OKAY);
    err_src_s.aw_ovf    = aw_fire && !aw_fifo_full_n;
    err_src_s.unexp_b   = m_bvalid && !last_fire_s && (b_pend_q == PEND_ZERO);
    if (!err_q && (|err_src_s)) begin
      err_d      = 1'b1;
      err_code_d = err_encode(err_src_s);
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= BEAT_ZERO;
      b_pend_q   <= PEND_ZERO;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      b_pend_q   <= b_pend_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_aw_wlast_ctrl.sv
// Self-checking bench for aw_wlast_ctrl: directed scenarios plus a randomized
// run, all compared each cycle against a queue-based burst model.
module tb_aw_wlast_ctrl;

  localparam int LEN_W     = 4;
  localparam int DEPTH_LOG = 2;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LEN_W-1:0]  wdma_awlen;
  logic              aw_fire;
  logic              aw_fifo_full_n;
  logic [DATA_W-1:0] src_wdata;
  logic              src_wvalid;
  logic              src_wready;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic              m_wlast;
  logic              m_bvalid;
  logic [1:0]        m_bresp;
  logic              m_bready;
  logic              idle;
  logic              err;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  aw_wlast_ctrl #(.LEN_W(LEN_W), .DEPTH_LOG(DEPTH_LOG), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .wdma_awlen(wdma_awlen), .aw_fire(aw_fire),
    .aw_fifo_full_n(aw_fifo_full_n), .src_wdata(src_wdata), .src_wvalid(src_wvalid),
    .src_wready(src_wready), .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .idle(idle), .err(err), .err_code(err_code)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queued burst lengths, beats done in head burst, Bs owed.
  int       mq[$];
  int       m_beat;
  int       m_bpend;
  logic     m_err;
  logic [1:0] m_code;
  logic     obs_wlast;
  logic     obs_fire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_beat  = 0;
    m_bpend = 0;
    m_err   = 1'b0;
    m_code  = 2'b00;
  endtask

  // Inputs are already driven; check outputs mid-cycle, then advance the model.
  task automatic step();
    bit empty, wv, wr_ok, wl, fire, last, was_full, ovf, bad, unexp;
    logic [1:0] code;
    #1;
    empty = (mq.size() == 0);
    wv    = src_wvalid && !empty;
    wr_ok = m_wready && !empty;
    wl    = 1'b0;
    if (!empty) wl = (m_beat == mq[0]);
    chk("m_wvalid", m_wvalid, wv);
    chk("src_wready", src_wready, wr_ok);
    chk("m_wlast", m_wlast, wl);
    chk("m_wdata", m_wdata, src_wdata);
    chk("full_n", aw_fifo_full_n, mq.size() < DEPTH);
    chk("idle", idle, empty && m_beat == 0 && m_bpend == 0);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("m_bready", m_bready, 1'b1);
    obs_wlast = m_wlast;
    obs_fire  = m_wvalid && m_wready;
    if (!rst_n) begin
      model_reset();
    end else begin
      fire     = wv && m_wready;
      last     = fire && wl;
      was_full = (mq.size() >= DEPTH);
      if (last) begin
        void'(mq.pop_front());
        m_beat = 0;
      end else if (fire) begin
        m_beat++;
      end
      ovf = 1'b0;
      if (aw_fire) begin
        if (was_full) ovf = 1'b1;
        else mq.push_back(int'(wdma_awlen));
      end
      unexp = 1'b0;
      if (last && !m_bvalid) m_bpend++;
      else if (m_bvalid && !last) begin
        if (m_bpend > 0) m_bpend--;
        else unexp = 1'b1;
      end
      bad  = m_bvalid && (m_bresp != 2'b00);
      code = bad ? 2'b01 : (ovf ? 2'b10 : (unexp ? 2'b11 : 2'b00));
      if (!m_err && code != 2'b00) begin
        m_err  = 1'b1;
        m_code = code;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic aw, input int len, input logic sv, input logic wr,
                     input logic bv, input logic [1:0] br);
    aw_fire    = aw;
    wdma_awlen = LEN_W'(len);
    src_wvalid = sv;
    m_wready   = wr;
    m_bvalid   = bv;
    m_bresp    = br;
    src_wdata  = {$urandom, $urandom};
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    int wl_pos[$];
    int beat;
    int fires;
    int cyc;
    int exp_pos[4];
    logic aw, bv;

    rst_n = 1'b0; aw_fire = 1'b0; wdma_awlen = '0; src_wvalid = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; src_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Single burst of 4 beats, then one OKAY response.
    drv(1'b1, 3, 1'b0, 1'b0, 1'b0, 2'b00);
    wl_pos.delete();
    for (int i = 1; i <= 4; i++) begin
      drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
      if (obs_wlast) wl_pos.push_back(i);
    end
    chk("s1_wlast_count", wl_pos.size(), 1);
    chk("s1_wlast_beat", (wl_pos.size() > 0) ? wl_pos[0] : -1, 4);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s1_idle", idle, 1'b1);

    // Fill the FIFO, overflow once, then stream all 22 beats.
    drv(1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1'b1, 1, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1'b1, 15, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1'b1, 2, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s2_full", aw_fifo_full_n, 1'b0);
    drv(1'b1, 9, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s2_err", err, 1'b1);
    chk("s2_err_code", err_code, 2'b10);
    wl_pos.delete();
    beat = 0;
    cyc  = 0;
    while (beat < 22 && cyc < 100) begin
      drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
      cyc++;
      if (obs_fire) begin
        beat++;
        if (obs_wlast) wl_pos.push_back(beat);
      end
    end
    chk("s2_beats", beat, 22);
    exp_pos = '{1, 3, 19, 22};
    chk("s2_wlast_n", wl_pos.size(), 4);
    for (int k = 0; k < 4; k++) chk("s2_wlast_pos", (k < wl_pos.size()) ? wl_pos[k] : -1, exp_pos[k]);
    for (int k = 0; k < 4; k++) drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Gating while empty, then wvalid one cycle after the push.
    do_reset();
    for (int i = 0; i < 3; i++) drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drv(1'b1, 1, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("s3_push_cycle_gated", obs_fire, 1'b0);
    drv(1'b0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    chk("s3_wvalid_next", m_wvalid, 1'b1);
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);

    // awlen 7 with random ready stalls: exactly 8 fires.
    drv(1'b1, 7, 1'b0, 1'b0, 1'b0, 2'b00);
    fires = 0;
    cyc   = 0;
    while (fires < 8 && cyc < 200) begin
      drv(1'b0, 0, 1'b1, logic'($urandom_range(0, 2) == 0), 1'b0, 2'b00);
      cyc++;
      if (obs_fire) fires++;
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
      if (obs_fire) fires++;
    end
    chk("s4_fires", fires, 8);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);

    // SLVERR response, then an unexpected B must not overwrite the code.
    drv(1'b1, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b10);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s5_code_bresp", err_code, 2'b01);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00);
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s5_code_kept", err_code, 2'b01);

    // Reset in the middle of a burst.
    do_reset();
    drv(1'b1, 5, 1'b0, 1'b0, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    rst_n = 1'b0;
    drv(1'b0, 0, 1'b1, 1'b1, 1'b0, 2'b00);
    rst_n = 1'b1;
    drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("s6_idle", idle, 1'b1);
    chk("s6_full_n", aw_fifo_full_n, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      aw = ($urandom_range(0, 2) == 0);
      if (mq.size() >= DEPTH && $urandom_range(0, 15) != 0) aw = 1'b0;
      bv = (m_bpend > 0) ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 40) == 0);
      drv(aw, int'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 3) != 0), bv,
          ($urandom_range(0, 30) == 0) ? 2'b10 : 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
